// File: rtl/sdram_arb.sv
// Round-robin burst arbiter between NREQ requesters and one SDRAM controller command port.
// Refresh requests are held until serviced and always go ahead of requesters.
module sdram_arb #(
    parameter int NREQ      = 4,
    parameter int ADDR_W    = 21,
    parameter int BURST_LEN = 8,
    parameter int TMO       = 255
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic [NREQ-1:0]         req_i,
    input  logic [NREQ-1:0]         req_we_i,
    input  logic [NREQ*ADDR_W-1:0]  req_addr_i,
    output logic [NREQ-1:0]         gnt_o,
    output logic [NREQ-1:0]         done_o,
    output logic [$clog2(NREQ)-1:0] owner_o,
    output logic                    busy_o,
    input  logic                    ref_req_i,
    output logic                    ref_ack_o,
    output logic                    cmd_valid_o,
    input  logic                    cmd_ready_i,
    output logic                    cmd_we_o,
    output logic                    cmd_ref_o,
    output logic [ADDR_W-1:0]       cmd_addr_o,
    input  logic                    beat_i,
    output logic                    err_tmo_o
);

    localparam int OW = $clog2(NREQ);
    localparam int BW = $clog2(BURST_LEN);
    localparam int TW = $clog2(TMO + 1);

    // state   | meaning
    // IDLE    | waiting; refresh wins over any requester
    // ISSUE   | burst command offered to the controller
    // BURST   | counting data beats, watching for a stalled transfer
    // REFRESH | refresh command offered to the controller
    typedef enum logic [1:0] {IDLE, ISSUE, BURST, REFRESH} state_t;

    state_t            state_q, state_d;
    logic              ref_pend_q, ref_pend_d;
    logic [OW-1:0]     last_owner_q, last_owner_d;
    logic [OW-1:0]     owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BW-1:0]     beat_cnt_q, beat_cnt_d;
    logic [TW-1:0]     tmo_cnt_q, tmo_cnt_d;

    logic              win_found;
    logic [OW-1:0]     win_idx;
    logic [OW-1:0]     cand_idx;
    int                cand;

    // Search starts just after the last owner so every requester gets a turn.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = int'(last_owner_q) + 1 + i;
            if (cand >= NREQ) cand = cand - NREQ;
            cand_idx = OW'(cand);
            if (!win_found && req_i[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        ref_pend_d   = ref_pend_q | ref_req_i;
        last_owner_d = last_owner_q;
        owner_d      = owner_q;
        we_d         = we_q;
        addr_d       = addr_q;
        beat_cnt_d   = beat_cnt_q;
        tmo_cnt_d    = tmo_cnt_q;
        gnt_o        = '0;
        done_o       = '0;
        ref_ack_o    = 1'b0;
        err_tmo_o    = 1'b0;
        cmd_valid_o  = 1'b0;
        cmd_we_o     = 1'b0;
        cmd_ref_o    = 1'b0;
        cmd_addr_o   = '0;
        unique case (state_q)
            IDLE: begin
                if (ref_pend_q) begin
                    state_d = REFRESH;
                end else if (win_found) begin
                    owner_d = win_idx;
                    we_d    = req_we_i[win_idx];
                    addr_d  = req_addr_i[win_idx*ADDR_W +: ADDR_W];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cmd_valid_o = 1'b1;
                cmd_we_o    = we_q;
                cmd_addr_o  = addr_q;
                if (cmd_ready_i) begin
                    gnt_o[owner_q] = 1'b1;
                    beat_cnt_d     = '0;
                    tmo_cnt_d      = '0;
                    state_d        = BURST;
                end
            end
            BURST: begin
                if (beat_i) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    tmo_cnt_d  = '0;
                    if (beat_cnt_q == BW'(BURST_LEN - 1)) begin
                        done_o[owner_q] = 1'b1;
                        last_owner_d    = owner_q;
                        state_d         = IDLE;
                    end
                end else if (tmo_cnt_q == TW'(TMO - 1)) begin
                    err_tmo_o       = 1'b1;
                    done_o[owner_q] = 1'b1;
                    last_owner_d    = owner_q;
                    state_d         = IDLE;
                end else if (tmo_cnt_q != TW'(TMO)) begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            REFRESH: begin
                cmd_valid_o = 1'b1;
                cmd_ref_o   = 1'b1;
                if (cmd_ready_i) begin
                    ref_ack_o  = 1'b1;
                    // A new refresh arriving in the accept cycle must not be lost.
                    ref_pend_d = ref_req_i;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o  = (state_q != IDLE);
    assign owner_o = owner_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q      <= IDLE;
            ref_pend_q   <= 1'b0;
            last_owner_q <= OW'(NREQ - 1);
            owner_q      <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            beat_cnt_q   <= '0;
            tmo_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            ref_pend_q   <= ref_pend_d;
            last_owner_q <= last_owner_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            beat_cnt_q   <= beat_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
        end
    end

endmodule

// File: tb/tb_sdram_arb.sv
// Bench for sdram_arb: fixed vector table, directed multi-cycle sequences, then
// randomized transactions checked against a transaction-level arbitration model.
module tb_sdram_arb;

    localparam int NREQ = 4;
    localparam int AW   = 21;
    localparam int BL   = 8;
    localparam int TMO  = 16;

    logic            clk;
    logic            rst_n;
    logic [3:0]      req_i, req_we_i, gnt_o, done_o;
    logic [4*AW-1:0] req_addr_i;
    logic [1:0]      owner_o;
    logic            busy_o, ref_req_i, ref_ack_o, cmd_valid_o, cmd_ready_i;
    logic            cmd_we_o, cmd_ref_o, beat_i, err_tmo_o;
    logic [AW-1:0]   cmd_addr_o;

    sdram_arb #(.NREQ(NREQ), .ADDR_W(AW), .BURST_LEN(BL), .TMO(TMO)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .req_i(req_i), .req_we_i(req_we_i),
        .req_addr_i(req_addr_i), .gnt_o(gnt_o), .done_o(done_o), .owner_o(owner_o),
        .busy_o(busy_o), .ref_req_i(ref_req_i), .ref_ack_o(ref_ack_o),
        .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i), .cmd_we_o(cmd_we_o),
        .cmd_ref_o(cmd_ref_o), .cmd_addr_o(cmd_addr_o), .beat_i(beat_i),
        .err_tmo_o(err_tmo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int n_chk = 0;
    int n_err = 0;
    int m_last;
    bit m_ref_pend;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    function automatic int rr_pick(input int last, input logic [3:0] v);
        for (int k = 1; k <= NREQ; k++)
            if (v[(last + k) % NREQ]) return (last + k) % NREQ;
        return -1;
    endfunction

    task automatic scramble();
        req_we_i = 4'($urandom);
        for (int i = 0; i < NREQ; i++) req_addr_i[i*AW +: AW] = AW'($urandom);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req_i = '0; beat_i = 1'b0; cmd_ready_i = 1'b0; ref_req_i = 1'b0;
        cyc();
        smp();
        chk("rst_ctl", {busy_o, cmd_valid_o, cmd_we_o, cmd_ref_o, ref_ack_o, err_tmo_o, gnt_o, done_o, owner_o}, '0);
        chk("rst_addr", cmd_addr_o, '0);
        cyc();
        rst_n = 1'b1;
        m_last = NREQ - 1;
        m_ref_pend = 1'b0;
    endtask

    // One complete transaction starting from an IDLE cycle; nbeats < BL forces a timeout.
    task automatic xact(input logic [3:0] v, input int nbeats, input int rdy_dly,
                        input int ref_at, input bit ref_on_ack, output int w);
        logic [AW-1:0] e_addr;
        logic          e_we;
        logic [3:0]    onehot;
        int            beats, silent;
        bit            fin, do_beat, full, tmo;
        bit            again;
        again = ref_on_ack;
        req_i = v; cmd_ready_i = 1'b0; ref_req_i = 1'b0; beat_i = 1'($urandom_range(0, 1));
        smp();
        chk("idle_busy", busy_o, 0);
        chk("idle_vld", cmd_valid_o, 0);
        cyc();
        beat_i = 1'b0;
        while (m_ref_pend) begin
            cmd_ready_i = 1'b0;
            smp();
            chk("ref_vld", {cmd_valid_o, cmd_ref_o, ref_ack_o}, 3'b110);
            cyc();
            cmd_ready_i = 1'b1; ref_req_i = again;
            smp();
            chk("ref_ack", {ref_ack_o, cmd_ref_o, gnt_o}, {2'b11, 4'b0000});
            cyc();
            cmd_ready_i = 1'b0; ref_req_i = 1'b0;
            m_ref_pend = again;
            again = 1'b0;
            smp();
            chk("ref_idle", {busy_o, cmd_valid_o}, 2'b00);
            cyc();
        end
        w = rr_pick(m_last, v);
        onehot = 4'(1 << w);
        e_we = req_we_i[w];
        e_addr = req_addr_i[w*AW +: AW];
        for (int d = 0; d < rdy_dly; d++) begin
            cmd_ready_i = 1'b0; beat_i = 1'($urandom_range(0, 1));
            smp();
            chk("iss_hold", {cmd_valid_o, cmd_ref_o, cmd_we_o, gnt_o, busy_o}, {2'b10, e_we, 4'b0000, 1'b1});
            chk("iss_addr", cmd_addr_o, e_addr);
            chk("iss_owner", owner_o, w);
            cyc();
            scramble();
        end
        cmd_ready_i = 1'b1; beat_i = 1'($urandom_range(0, 1));
        smp();
        chk("gnt", gnt_o, onehot);
        chk("gnt_cmd", {cmd_valid_o, cmd_ref_o, cmd_we_o}, {2'b10, e_we});
        chk("gnt_addr", cmd_addr_o, e_addr);
        cyc();
        cmd_ready_i = 1'b0; req_i = v & ~onehot;
        beats = 0; silent = 0; fin = 1'b0;
        for (int c = 0; c < 200 && !fin; c++) begin
            do_beat = (beats < nbeats) && (silent >= 10 || $urandom_range(0, 2) != 0);
            beat_i = do_beat;
            ref_req_i = do_beat && (beats + 1 == ref_at);
            if (ref_req_i) m_ref_pend = 1'b1;
            full = do_beat && (beats == BL - 1);
            tmo = !do_beat && (silent == TMO - 1);
            smp();
            chk("bst_done", done_o, (full || tmo) ? onehot : 4'b0000);
            chk("bst_err", err_tmo_o, tmo);
            chk("bst_ctl", {busy_o, cmd_valid_o, gnt_o, owner_o}, {2'b10, 4'b0000, 2'(w)});
            if (do_beat) begin beats++; silent = 0; end
            else silent++;
            fin = full || tmo;
            cyc();
        end
        chk("bst_bound", fin, 1);
        beat_i = 1'b0; ref_req_i = 1'b0;
        m_last = w;
    endtask

    typedef struct {
        logic          rst;
        logic [3:0]    req;
        logic          rdy;
        logic          bt;
        logic [3:0]    gnt;
        logic [3:0]    done;
        logic          busy;
        logic          vld;
        logic          we;
        logic [AW-1:0] addr;
        logic [1:0]    own;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rst, input logic [3:0] req, input logic rdy, input logic bt,
                                input logic [3:0] gnt, input logic [3:0] done, input logic busy,
                                input logic vld, input logic we, input logic [AW-1:0] addr,
                                input logic [1:0] own);
        vec_t r;
        r.rst = rst; r.req = req; r.rdy = rdy; r.bt = bt; r.gnt = gnt; r.done = done;
        r.busy = busy; r.vld = vld; r.we = we; r.addr = addr; r.own = own;
        return r;
    endfunction

    int w;
    int order[5] = '{0, 1, 2, 3, 0};

    initial begin
        rst_n = 1'b0; req_i = '0; beat_i = 1'b0; cmd_ready_i = 1'b0; ref_req_i = 1'b0;
        req_we_i = 4'b0001;
        req_addr_i[0*AW +: AW] = 21'h00100;
        req_addr_i[1*AW +: AW] = 21'h1ABCD;
        req_addr_i[2*AW +: AW] = 21'h0F0F0;
        req_addr_i[3*AW +: AW] = 21'h1FFFF;

        // single write burst, stalled issue, reset in mid-burst
        tbl.push_back(mk(0, 4'h0, 0, 0, 4'h0, 4'h0, 0, 0, 0, 21'h0, 0));
        tbl.push_back(mk(1, 4'h1, 0, 1, 4'h0, 4'h0, 0, 0, 0, 21'h0, 0));
        tbl.push_back(mk(1, 4'h1, 1, 0, 4'h1, 4'h0, 1, 1, 1, 21'h00100, 0));
        for (int i = 0; i < 2; i++) tbl.push_back(mk(1, 4'h0, 0, 1, 4'h0, 4'h0, 1, 0, 0, 21'h0, 0));
        tbl.push_back(mk(1, 4'h0, 0, 0, 4'h0, 4'h0, 1, 0, 0, 21'h0, 0));
        for (int i = 0; i < 5; i++) tbl.push_back(mk(1, 4'h0, 0, 1, 4'h0, 4'h0, 1, 0, 0, 21'h0, 0));
        tbl.push_back(mk(1, 4'h0, 0, 1, 4'h0, 4'h1, 1, 0, 0, 21'h0, 0));
        tbl.push_back(mk(1, 4'h2, 0, 0, 4'h0, 4'h0, 0, 0, 0, 21'h0, 0));
        for (int i = 0; i < 5; i++) tbl.push_back(mk(1, 4'h2, 0, 0, 4'h0, 4'h0, 1, 1, 0, 21'h1ABCD, 1));
        tbl.push_back(mk(1, 4'h2, 1, 0, 4'h2, 4'h0, 1, 1, 0, 21'h1ABCD, 1));
        tbl.push_back(mk(1, 4'h0, 0, 0, 4'h0, 4'h0, 1, 0, 0, 21'h0, 1));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 4'h0, 0, 1, 4'h0, 4'h0, 1, 0, 0, 21'h0, 1));
        tbl.push_back(mk(0, 4'h0, 0, 1, 4'h0, 4'h0, 1, 0, 0, 21'h0, 1));
        tbl.push_back(mk(1, 4'h0, 0, 1, 4'h0, 4'h0, 0, 0, 0, 21'h0, 0));
        tbl.push_back(mk(1, 4'hF, 0, 0, 4'h0, 4'h0, 0, 0, 0, 21'h0, 0));
        tbl.push_back(mk(1, 4'hF, 1, 0, 4'h1, 4'h0, 1, 1, 1, 21'h00100, 0));

        cyc();
        cyc();
        foreach (tbl[i]) begin
            rst_n = tbl[i].rst; req_i = tbl[i].req; cmd_ready_i = tbl[i].rdy; beat_i = tbl[i].bt;
            smp();
            chk($sformatf("t%0d_gnt", i), gnt_o, tbl[i].gnt);
            chk($sformatf("t%0d_done", i), done_o, tbl[i].done);
            chk($sformatf("t%0d_busy", i), busy_o, tbl[i].busy);
            chk($sformatf("t%0d_vld", i), cmd_valid_o, tbl[i].vld);
            chk($sformatf("t%0d_we", i), cmd_we_o, tbl[i].we);
            chk($sformatf("t%0d_addr", i), cmd_addr_o, tbl[i].addr);
            chk($sformatf("t%0d_own", i), owner_o, tbl[i].own);
            chk($sformatf("t%0d_aux", i), {cmd_ref_o, ref_ack_o, err_tmo_o}, 3'b000);
            cyc();
        end

        do_reset();
        for (int i = 0; i < 5; i++) begin
            xact(4'hF, BL, 0, 0, 1'b0, w);
            chk($sformatf("rr_order%0d", i), w, order[i]);
        end

        xact(4'b0100, BL, 0, 3, 1'b0, w);
        chk("ref_burst_owner", w, 2);
        chk("ref_pend_model", m_ref_pend, 1);
        xact(4'b1000, BL, 0, 0, 1'b0, w);
        chk("after_ref_owner", w, 3);

        xact(4'b0010, 3, 0, 0, 1'b0, w);
        chk("tmo_owner", w, 1);

        xact(4'b0001, BL, 1, 2, 1'b0, w);
        xact(4'b0010, BL, 0, 0, 1'b1, w);
        chk("double_ref_owner", w, 1);

        do_reset();
        for (int t = 0; t < 40; t++) begin
            scramble();
            xact(4'($urandom_range(1, 15)),
                 ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, BL - 1)) : BL,
                 int'($urandom_range(0, 3)),
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, BL)) : 0,
                 1'($urandom_range(0, 3) == 0), w);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/sdram_arb.md
SDRAM_ARB -- requirements
Module: sdram_arb

Interface
REQ-001 Parameter NREQ, default 4, number of requesters (ADC1 wr, ADC2 wr, DAC1 rd, DAC2 rd).
REQ-002 Parameter ADDR_W, default 21, burst start address width (ba 2 + row 11 + col 8).
REQ-003 Parameter BURST_LEN, default 8, data beats per burst.
REQ-004 Parameter TMO, default 255, max cycles between consecutive beats before abort.
REQ-005 clk  in  1  system clock; the block uses one clock.
REQ-006 rst_n  in  1  synchronous active-low reset, sampled on rising clk.
REQ-007 req  in  NREQ  per-requester burst request; held high until the matching gnt.
REQ-008 req_we  in  NREQ  per-requester direction, 1=write, 0=read.
REQ-009 req_addr  in  NREQ*ADDR_W  per-requester start address, slice i = requester i.
REQ-010 gnt  out  NREQ  one-hot pulse: the requester's command has been accepted.
REQ-011 done  out  NREQ  one-hot pulse: the requester's last beat has been transferred.
REQ-012 owner  out  $clog2(NREQ)  index of the current or last burst owner.
REQ-013 busy  out  1  high in every state other than IDLE.
REQ-014 ref_req  in  1  refresh-due pulse from the refresh timer.
REQ-015 ref_ack  out  1  pulse: refresh command accepted.
REQ-016 cmd_valid / cmd_ready  out / in  1 / 1  command handshake towards the SDRAM controller.
REQ-017 cmd_we, cmd_ref  out  1, 1  command type; cmd_ref has priority over cmd_we.
REQ-018 cmd_addr  out  ADDR_W  command start address.
REQ-019 beat  in  1  controller pulse, one per transferred data word.
REQ-020 err_tmo  out  1  pulse: burst aborted on timeout.

Function
REQ-021 The FSM SHALL have 4 states: IDLE, ISSUE, BURST and REFRESH.
REQ-022 IDLE: if ref_pend=1 go to REFRESH; else if |req go to ISSUE, latching the winner index, req_we and req_addr; else stay.
REQ-023 The winner SHALL be chosen round-robin, searching from (last_owner+1) mod NREQ upward with wrap; last_owner resets to NREQ-1, so requester 0 wins first.
REQ-024 ISSUE: cmd_valid=1, with cmd_we and cmd_addr taken from the latched values; on cmd_valid&cmd_ready, pulse gnt[owner] in that same cycle, clear the beat counter and the timeout counter, and go to BURST.
REQ-025 cmd_valid, cmd_we, cmd_addr and cmd_ref SHALL stay stable while cmd_valid=1 and cmd_ready=0.
REQ-026 BURST: each beat increments beat_cnt and clears the timeout counter; when beat arrives with beat_cnt=BURST_LEN-1, pulse done[owner] in that cycle, set last_owner=owner and go to IDLE.
REQ-027 BURST: when no beat arrives for TMO consecutive cycles, pulse err_tmo, pulse done[owner], set last_owner=owner and go to IDLE.
REQ-028 Beats received outside BURST SHALL be ignored.
REQ-029 ref_req SHALL set the sticky flag ref_pend in any state; ref_pend is cleared on refresh acceptance; ref_req in the same cycle as acceptance leaves ref_pend set.
REQ-030 A refresh SHALL never preempt ISSUE or BURST; it is serviced at the next IDLE, ahead of all requesters.
REQ-031 REFRESH: cmd_valid=1 and cmd_ref=1; on cmd_ready, pulse ref_ack and go to IDLE; last_owner is unchanged.
REQ-032 Minimum latency SHALL be: req seen in IDLE at cycle N -> cmd_valid=1 at N+1 -> gnt at N+1 if cmd_ready=1.
REQ-033 After a burst completes, the block SHALL return to IDLE for exactly 1 cycle before the next ISSUE or REFRESH.
REQ-034 gnt, done, ref_ack and err_tmo SHALL be registered or state-decoded single-cycle pulses, with at most one bit high.
REQ-035 beat_cnt SHALL be $clog2(BURST_LEN) bits wide, and the timeout counter $clog2(TMO+1) bits wide, saturating.

Reset
REQ-036 While rst_n=0 at a rising clk: state=IDLE, ref_pend=0, beat_cnt=0, timeout counter=0, last_owner=NREQ-1, owner=0.
REQ-037 While rst_n=0 at a rising clk: cmd_valid, cmd_we, cmd_ref, cmd_addr, gnt, done, busy, ref_ack and err_tmo SHALL all be 0.
REQ-038 Reset asserted mid-burst SHALL abandon the burst with no done pulse; behaviour is per REQ-036 and REQ-037 from the next cycle.

Verification
REQ-039 Scenario: req=4'b0001, addr0=0x00100, we=1, cmd_ready=1, 8 beats -> gnt=0001 at cycle 1, done=0001 on beat 8, busy low 1 cycle later.
REQ-040 Scenario: req=4'b1111 held -> grant order 0,1,2,3,0; each owner receives exactly one done per gnt.
REQ-041 Scenario: ref_req pulse during beat 3 of a burst owned by requester 2, with req=4'b1000 -> burst completes, then REFRESH (cmd_ref=1, ref_ack), then gnt=1000.
REQ-042 Scenario: cmd_ready=0 for 5 cycles in ISSUE -> cmd_addr, cmd_we and cmd_valid stay constant, and gnt appears only in the cycle cmd_ready=1.
REQ-043 Scenario: TMO=16, only 3 beats delivered -> err_tmo and done[owner] pulse 16 cycles after beat 3, then FSM in IDLE.
REQ-044 Scenario: rst_n=0 for 1 cycle during beat 5 -> no done pulse; all outputs 0; next req is granted to requester 0.
